// File: rtl/dcpu_bus.sv
// dcpu_bus: bus controller decoding dcpu core accesses to on-chip RAM, an 8-bit I/O port or an unmapped hole.
// Optional I/O watchdog enabled by defining DCPU_BUS_TIMEOUT_EN.
module dcpu_bus #(
    parameter int RAM_AW  = 12,
    parameter int TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cpu_cs,
    input  logic              i_cpu_we,
    input  logic [15:0]       i_cpu_addr,
    input  logic [15:0]       i_cpu_dat,
    output logic [15:0]       o_cpu_dat,
    output logic              o_cpu_ack,
    output logic              o_ram_en,
    output logic              o_ram_we,
    output logic [RAM_AW-1:0] o_ram_addr,
    output logic [15:0]       o_ram_dat,
    input  logic [15:0]       i_ram_dat,
    output logic              o_io_req,
    output logic              o_io_we,
    output logic [7:0]        o_io_addr,
    output logic [15:0]       o_io_dat,
    input  logic [15:0]       i_io_dat,
    input  logic              i_io_ack,
    output logic              o_bus_err
);

    if (RAM_AW < 8 || RAM_AW > 15) begin : g_bad_ram_aw
        $error("dcpu_bus: RAM_AW out of range 8..15");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("dcpu_bus: TIMEOUT out of range 1..255");
    end

    typedef enum logic [1:0] {IDLE, RAM_ACK, IO_WAIT, ACK} state_t;

    state_t      state_reg;
    logic        cpu_ack_reg;
    logic        bus_err_reg;
    logic        ram_rd_reg;
    logic [15:0] cpu_dat_reg;
    logic        io_req_reg;
    logic        io_we_reg;
    logic [7:0]  io_addr_reg;
    logic [15:0] io_dat_reg;

    logic io_hit;
    logic ram_hit;

    assign io_hit  = (i_cpu_addr[15:8] == 8'hFF);
    assign ram_hit = (i_cpu_addr[15:RAM_AW] == '0);

    // RAM strobes are issued straight from the decode so read data lands in RAM_ACK.
    assign o_ram_en   = (state_reg == IDLE) && i_cpu_cs && ram_hit && !i_reset;
    assign o_ram_we   = o_ram_en && i_cpu_we;
    assign o_ram_addr = i_cpu_addr[RAM_AW-1:0];
    assign o_ram_dat  = i_cpu_dat;

`ifdef DCPU_BUS_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    logic [7:0] tmo_cnt_reg;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg   <= IDLE;
            cpu_ack_reg <= 1'b0;
            bus_err_reg <= 1'b0;
            ram_rd_reg  <= 1'b0;
            cpu_dat_reg <= 16'h0000;
            io_req_reg  <= 1'b0;
            io_we_reg   <= 1'b0;
            io_addr_reg <= 8'h00;
            io_dat_reg  <= 16'h0000;
`ifdef DCPU_BUS_TIMEOUT_EN
            tmo_cnt_reg <= 8'h00;
`endif
        end else begin
            // Acknowledge-side registers are single-cycle unless re-armed below.
            cpu_ack_reg <= 1'b0;
            bus_err_reg <= 1'b0;
            ram_rd_reg  <= 1'b0;
            cpu_dat_reg <= 16'h0000;
            case (state_reg)
                IDLE: begin
                    if (i_cpu_cs) begin
                        if (io_hit) begin
                            io_req_reg  <= 1'b1;
                            io_we_reg   <= i_cpu_we;
                            io_addr_reg <= i_cpu_addr[7:0];
                            io_dat_reg  <= i_cpu_dat;
                            state_reg   <= IO_WAIT;
`ifdef DCPU_BUS_TIMEOUT_EN
                            tmo_cnt_reg <= 8'h00;
`endif
                        end else if (ram_hit) begin
                            cpu_ack_reg <= 1'b1;
                            ram_rd_reg  <= ~i_cpu_we;
                            state_reg   <= RAM_ACK;
                        end else begin
                            cpu_ack_reg <= 1'b1;
                            bus_err_reg <= 1'b1;
                            state_reg   <= ACK;
                        end
                    end
                end
                RAM_ACK: state_reg <= IDLE;
                IO_WAIT: begin
                    if (i_io_ack) begin
                        io_req_reg  <= 1'b0;
                        cpu_dat_reg <= io_we_reg ? 16'h0000 : i_io_dat;
                        cpu_ack_reg <= 1'b1;
                        state_reg   <= ACK;
`ifdef DCPU_BUS_TIMEOUT_EN
                    end else if (tmo_cnt_reg == TIMEOUT_LAST) begin
                        io_req_reg  <= 1'b0;
                        cpu_dat_reg <= 16'hDEAD;
                        bus_err_reg <= 1'b1;
                        cpu_ack_reg <= 1'b1;
                        state_reg   <= ACK;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
`endif
                    end
                end
                ACK:     state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign o_cpu_ack = cpu_ack_reg;
    assign o_bus_err = bus_err_reg;
    assign o_cpu_dat = ram_rd_reg ? i_ram_dat : cpu_dat_reg;
    assign o_io_req  = io_req_reg;
    assign o_io_we   = io_we_reg;
    assign o_io_addr = io_addr_reg;
    assign o_io_dat  = io_dat_reg;

endmodule

// File: tb/tb_dcpu_bus.sv
// Self-checking bench for dcpu_bus: directed cases plus random traffic against a transaction-level model.
// Timeout cases are exercised when DCPU_BUS_TIMEOUT_EN is defined.
module tb_dcpu_bus;

    localparam int RAM_AW  = 12;
    localparam int TIMEOUT = 15;

    logic              i_clk = 1'b0;
    logic              i_reset = 1'b1;
    logic              i_cpu_cs = 1'b0;
    logic              i_cpu_we = 1'b0;
    logic [15:0]       i_cpu_addr = 16'h0000;
    logic [15:0]       i_cpu_dat = 16'h0000;
    logic [15:0]       o_cpu_dat;
    logic              o_cpu_ack;
    logic              o_ram_en;
    logic              o_ram_we;
    logic [RAM_AW-1:0] o_ram_addr;
    logic [15:0]       o_ram_dat;
    logic [15:0]       i_ram_dat;
    logic              o_io_req;
    logic              o_io_we;
    logic [7:0]        o_io_addr;
    logic [15:0]       o_io_dat;
    logic [15:0]       i_io_dat = 16'h0000;
    logic              i_io_ack = 1'b0;
    logic              o_bus_err;

    int n_assert = 0;
    int n_fail   = 0;
    int n_txn    = 0;
    logic tb_init = 1'b1;

    dcpu_bus #(.RAM_AW(RAM_AW), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_cpu_cs(i_cpu_cs), .i_cpu_we(i_cpu_we), .i_cpu_addr(i_cpu_addr), .i_cpu_dat(i_cpu_dat),
        .o_cpu_dat(o_cpu_dat), .o_cpu_ack(o_cpu_ack),
        .o_ram_en(o_ram_en), .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr), .o_ram_dat(o_ram_dat),
        .i_ram_dat(i_ram_dat),
        .o_io_req(o_io_req), .o_io_we(o_io_we), .o_io_addr(o_io_addr), .o_io_dat(o_io_dat),
        .i_io_dat(i_io_dat), .i_io_ack(i_io_ack), .o_bus_err(o_bus_err)
    );

    always #5 i_clk = ~i_clk;

    // Synchronous RAM attached to the RAM port.
    logic [15:0] mem [0:(1<<RAM_AW)-1];
    logic [15:0] ram_q;
    assign i_ram_dat = ram_q;
    always @(posedge i_clk) begin
        if (tb_init) begin
            for (int i = 0; i < (1<<RAM_AW); i++) mem[i] <= 16'h0000;
        end else if (o_ram_en) begin
            if (o_ram_we) mem[o_ram_addr] <= o_ram_dat;
            ram_q <= mem[o_ram_addr];
        end
    end

    // Expected RAM contents, updated only by accesses that hit RAM.
    logic [15:0] shadow [0:(1<<RAM_AW)-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One core transaction starting in an IDLE cycle; io_wait = peripheral wait cycles before acking.
    task automatic access(input logic we, input logic [15:0] addr, input logic [15:0] wdat,
                          input int io_wait, input logic [15:0] io_rdat);
        int kind, lat, req_last;
        logic [15:0] exp_dat;
        logic exp_err;
        kind = (addr[15:8] == 8'hFF) ? 1 : (int'(addr) < (1<<RAM_AW)) ? 0 : 2;
        req_last = 0;
        exp_err  = 1'b0;
        exp_dat  = 16'h0000;
        if (kind == 0) begin
            if (!we) exp_dat = shadow[addr[RAM_AW-1:0]];
            else     shadow[addr[RAM_AW-1:0]] = wdat;
        end else if (kind == 1) begin
            req_last = io_wait + 1;
            if (!we) exp_dat = io_rdat;
`ifdef DCPU_BUS_TIMEOUT_EN
            if (io_wait + 1 > TIMEOUT) begin
                req_last = TIMEOUT;
                exp_dat  = 16'hDEAD;
                exp_err  = 1'b1;
            end
`endif
        end else begin
            exp_err = 1'b1;
        end
        lat = (kind == 1) ? req_last + 1 : 1;

        @(posedge i_clk); #1;
        i_cpu_cs   = 1'b1;
        i_cpu_we   = we;
        i_cpu_addr = addr;
        i_cpu_dat  = wdat;
        i_io_ack   = 1'($urandom);
        i_io_dat   = 16'($urandom);
        #1;
        chk("c0_ram_en", o_ram_en, (kind == 0));
        chk("c0_ram_we", o_ram_we, (kind == 0) && we);
        if (kind == 0) begin
            chk("c0_ram_addr", o_ram_addr, addr[RAM_AW-1:0]);
            chk("c0_ram_dat", o_ram_dat, wdat);
        end
        chk("c0_ack", o_cpu_ack, 0);
        for (int c = 1; c <= lat; c++) begin
            @(posedge i_clk); #1;
            i_cpu_cs = 1'($urandom);
            i_io_ack = (kind == 1 && c <= req_last) ? (c == io_wait + 1) : 1'($urandom);
            i_io_dat = (c == io_wait + 1) ? io_rdat : 16'($urandom);
            #1;
            chk("ack", o_cpu_ack, (c == lat));
            chk("io_req", o_io_req, (kind == 1 && c <= req_last));
            chk("bus_err", o_bus_err, (c == lat) && exp_err);
            chk("ram_en_busy", o_ram_en, 0);
            if (kind == 1 && c == 1) begin
                chk("io_addr", o_io_addr, addr[7:0]);
                chk("io_we", o_io_we, we);
                chk("io_dat", o_io_dat, wdat);
            end
            if (c == lat) chk("cpu_dat", o_cpu_dat, exp_dat);
        end
        n_txn++;
        $display("txn %0d: we=%0d addr=%h wdat=%h kind=%0d lat=%0d exp_dat=%h exp_err=%0d got_dat=%h",
                 n_txn, we, addr, wdat, kind, lat, exp_dat, exp_err, o_cpu_dat);
    endtask

    initial begin
        int sel, iw;
        logic [15:0] a;
        for (int i = 0; i < (1<<RAM_AW); i++) shadow[i] = 16'h0000;

        // Reset with a RAM write pending on the bus: no strobes, all outputs cleared.
        i_cpu_cs = 1'b1; i_cpu_we = 1'b1; i_cpu_addr = 16'h0010; i_cpu_dat = 16'h5555;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_ram_en", o_ram_en, 0);
        chk("rst_ram_we", o_ram_we, 0);
        chk("rst_ack", o_cpu_ack, 0);
        chk("rst_cpu_dat", o_cpu_dat, 0);
        chk("rst_io_req", o_io_req, 0);
        chk("rst_io_we", o_io_we, 0);
        chk("rst_io_addr", o_io_addr, 0);
        chk("rst_io_dat", o_io_dat, 0);
        chk("rst_bus_err", o_bus_err, 0);
        i_reset = 1'b0; tb_init = 1'b0; i_cpu_cs = 1'b0;

        // Directed cases.
        access(1'b1, 16'h0010, 16'h1234, 0, 16'h0000);
        access(1'b0, 16'h0010, 16'h0000, 0, 16'h0000);
        access(1'b1, 16'h0001, 16'hA5A5, 0, 16'h0000);
        access(1'b0, 16'h0000, 16'h0000, 0, 16'h0000);
        access(1'b0, 16'h0001, 16'h0000, 0, 16'h0000);
        access(1'b0, 16'hFF05, 16'h0000, 3, 16'hBEEF);
        access(1'b1, 16'hFF7E, 16'hC0DE, 0, 16'h1111);
        access(1'b0, 16'h8000, 16'h0000, 0, 16'h0000);
        access(1'b1, 16'h1010, 16'h9999, 0, 16'h0000);
        access(1'b0, 16'h0FFF, 16'h0000, 0, 16'h0000);
        access(1'b0, 16'h0010, 16'h0000, 0, 16'h0000);
`ifdef DCPU_BUS_TIMEOUT_EN
        access(1'b0, 16'hFF10, 16'h0000, 1000, 16'h0000);
        access(1'b0, 16'hFF11, 16'h0000, TIMEOUT - 1, 16'h5A5A);
`endif

        // Reset asserted while waiting on the I/O port.
        @(posedge i_clk); #1;
        i_cpu_cs = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = 16'hFF22; i_io_ack = 1'b0;
        @(posedge i_clk); #1;
        chk("mid_io_req_pre", o_io_req, 1);
        @(posedge i_clk); #1;
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        chk("mid_io_req", o_io_req, 0);
        chk("mid_ack", o_cpu_ack, 0);
        chk("mid_io_addr", o_io_addr, 0);
        i_reset = 1'b0; i_cpu_cs = 1'b0; i_io_ack = 1'b1;
        repeat (2) begin
            @(posedge i_clk); #1;
            chk("post_rst_ack", o_cpu_ack, 0);
        end
        i_io_ack = 1'b0;
        access(1'b0, 16'hFF22, 16'h0000, 1, 16'h7777);
        access(1'b0, 16'h0FFF, 16'h0000, 0, 16'h0000);

        // Random traffic.
        for (int t = 0; t < 150; t++) begin
            sel = $urandom_range(0, 3);
`ifdef DCPU_BUS_TIMEOUT_EN
            iw = $urandom_range(0, TIMEOUT + 3);
`else
            iw = $urandom_range(0, 5);
`endif
            if (sel <= 1)      a = 16'($urandom_range(0, 63));
            else if (sel == 2) a = 16'hFF00 | 16'($urandom_range(0, 255));
            else               a = 16'($urandom_range(1 << RAM_AW, 16'hFEFF));
            if (t % 10 == 0 && sel <= 1) a = 16'($urandom_range(0, (1 << RAM_AW) - 1));
            access(1'($urandom), a, 16'($urandom), iw, 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
